oled_spi_sink: RTL and testbench

//  Receive-side model of the write-only 4-wire SSD1306 OLED SPI link. Oversamples sck/mosi/dc/cs/reset
//  on clk, assembles MSB-first bytes, and decodes command bytes (dc=0) into display state. Data bytes
//  (dc=1) become framebuffer writes in horizontal addressing order. Used as an on-chip loopback

---
 rtl/oled_spi_sink.sv | 232 +++++++++++++++++++++++
 tb/tb_oled_spi_sink.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_sink.sv
// Receive side of the write-only 4-wire SSD1306 SPI link: oversampled byte
// assembly, command decode into display state, and data bytes to framebuffer writes.
module oled_spi_sink #(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 128,
    parameter int PAGES       = 8,
    localparam int CW         = $clog2(COLS),
    localparam int PW         = $clog2(PAGES),
    localparam int AW         = $clog2(COLS * PAGES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          oled_sck,
    input  logic          oled_mosi,
    input  logic          oled_dc,
    input  logic          oled_cs,
    input  logic          oled_reset,
    output logic          fb_we,
    output logic [AW-1:0] fb_addr,
    output logic [7:0]    fb_wdata,
    output logic          cmd_strobe,
    output logic [7:0]    cmd_byte,
    output logic          display_on,
    output logic [7:0]    contrast,
    output logic          inverted
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARG1 = 2'd1;
    localparam logic [1:0] ST_ARG2 = 2'd2;

    // Synchronizer lanes {reset, cs, dc, mosi, sck}; idle levels chosen so
    // release from reset never fakes an sck edge or a panel reset.
    localparam logic [4:0] SYNC_RST = 5'b11001;

    logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
    logic sck_s, mosi_s, dc_s, cs_s, rst_s;

    logic          sck_prev_q, sck_prev_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [6:0]    shift_q, shift_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    op_q, op_d;
    logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic          fb_we_q, fb_we_d;
    logic [AW-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]    fb_wdata_q, fb_wdata_d;
    logic          cmd_strobe_q, cmd_strobe_d;
    logic [7:0]    cmd_byte_q, cmd_byte_d;
    logic          display_on_q, display_on_d;
    logic [7:0]    contrast_q, contrast_d;
    logic          inverted_q, inverted_d;

    logic          sck_rise;
    logic [7:0]    byte_w;

    assign {rst_s, cs_s, dc_s, mosi_s, sck_s} = sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign byte_w   = {shift_q, mosi_s};

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], {oled_reset, oled_cs, oled_dc, oled_mosi, oled_sck}};
    end

    always_comb begin
        sck_prev_d   = sck_s;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        state_d      = state_q;
        op_d         = op_q;
        col_d        = col_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_d       = page_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;
        cmd_strobe_d = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        display_on_d = display_on_q;
        contrast_d   = contrast_q;
        inverted_d   = inverted_q;

        if (cs_s) begin
            cnt_d   = 3'd0;
            shift_d = 7'd0;
        end else if (sck_rise) begin
            shift_d = byte_w[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                if (dc_s) begin
                    // Data cancels any pending argument but is still written.
                    state_d    = ST_IDLE;
                    fb_we_d    = 1'b1;
                    fb_addr_d  = AW'(page_q) * AW'(COLS) + AW'(col_q);
                    fb_wdata_d = byte_w;
                    if (col_q == col_end_q) begin
                        col_d = col_start_q;
                        if (page_q == page_end_q)
                            page_d = page_start_q;
                        else
                            page_d = (page_q == PW'(PAGES - 1)) ? '0 : page_q + 1'b1;
                    end else begin
                        col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
                    end
                end else begin
                    cmd_strobe_d = 1'b1;
                    cmd_byte_d   = byte_w;
                    case (state_q)
                        ST_IDLE: begin
                            case (byte_w)
                                8'hAE: display_on_d = 1'b0;
                                8'hAF: display_on_d = 1'b1;
                                8'hA6: inverted_d   = 1'b0;
                                8'hA7: inverted_d   = 1'b1;
                                8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D,
                                8'h21, 8'h22: begin
                                    state_d = ST_ARG1;
                                    op_d    = byte_w;
                                end
                                default: ;
                            endcase
                        end
                        ST_ARG1: begin
                            if (op_q == 8'h21) begin
                                col_start_d = byte_w[CW-1:0];
                                state_d     = ST_ARG2;
                            end else if (op_q == 8'h22) begin
                                page_start_d = byte_w[PW-1:0];
                                state_d      = ST_ARG2;
                            end else begin
                                if (op_q == 8'h81) contrast_d = byte_w;
                                state_d = ST_IDLE;
                            end
                        end
                        default: begin
                            if (op_q == 8'h21) begin
                                col_end_d = byte_w[CW-1:0];
                                col_d     = col_start_q;
                            end else begin
                                page_end_d = byte_w[PW-1:0];
                                page_d     = page_start_q;
                            end
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
        end

        // Panel reset is synchronous and held for as long as the pin is low.
        if (!rst_s) begin
            cnt_d        = 3'd0;
            shift_d      = 7'd0;
            state_d      = ST_IDLE;
            op_d         = 8'd0;
            col_d        = '0;
            col_start_d  = '0;
            col_end_d    = CW'(COLS - 1);
            page_d       = '0;
            page_start_d = '0;
            page_end_d   = PW'(PAGES - 1);
            fb_we_d      = 1'b0;
            fb_addr_d    = '0;
            fb_wdata_d   = 8'd0;
            cmd_strobe_d = 1'b0;
            cmd_byte_d   = 8'd0;
            display_on_d = 1'b0;
            contrast_d   = 8'h7F;
            inverted_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= {SYNC_STAGES{SYNC_RST}};
            sck_prev_q   <= 1'b1;
            cnt_q        <= 3'd0;
            shift_q      <= 7'd0;
            state_q      <= ST_IDLE;
            op_q         <= 8'd0;
            col_q        <= '0;
            col_start_q  <= '0;
            col_end_q    <= CW'(COLS - 1);
            page_q       <= '0;
            page_start_q <= '0;
            page_end_q   <= PW'(PAGES - 1);
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= 8'd0;
            cmd_strobe_q <= 1'b0;
            cmd_byte_q   <= 8'd0;
            display_on_q <= 1'b0;
            contrast_q   <= 8'h7F;
            inverted_q   <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            sck_prev_q   <= sck_prev_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            state_q      <= state_d;
            op_q         <= op_d;
            col_q        <= col_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_q       <= page_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            cmd_strobe_q <= cmd_strobe_d;
            cmd_byte_q   <= cmd_byte_d;
            display_on_q <= display_on_d;
            contrast_q   <= contrast_d;
            inverted_q   <= inverted_d;
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign cmd_strobe = cmd_strobe_q;
    assign cmd_byte   = cmd_byte_q;
    assign display_on = display_on_q;
    assign contrast   = contrast_q;
    assign inverted   = inverted_q;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: reset, init stream, full-frame fill,
// address windows, cs abort and panel reset.
module tb_oled_spi_sink;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       oled_sck = 1'b1, oled_mosi = 1'b0, oled_dc = 1'b0, oled_cs = 1'b1, oled_reset = 1'b1;
    logic       fb_we, cmd_strobe, display_on, inverted;
    logic [9:0] fb_addr;
    logic [7:0] fb_wdata, cmd_byte, contrast;

    oled_spi_sink dut (
        .clk(clk), .rst_n(rst_n),
        .oled_sck(oled_sck), .oled_mosi(oled_mosi), .oled_dc(oled_dc),
        .oled_cs(oled_cs), .oled_reset(oled_reset),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .cmd_strobe(cmd_strobe), .cmd_byte(cmd_byte),
        .display_on(display_on), .contrast(contrast), .inverted(inverted)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int we_cnt = 0, cmd_cnt = 0, wide_cnt = 0;
    logic [9:0] addr_q[$];
    logic [7:0] data_q[$];
    logic we_prev = 1'b0, cmd_prev = 1'b0;

    // Strobe recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (fb_we) begin
            we_cnt++;
            addr_q.push_back(fb_addr);
            data_q.push_back(fb_wdata);
        end
        if (cmd_strobe) cmd_cnt++;
        if ((fb_we && we_prev) || (cmd_strobe && cmd_prev)) wide_cnt++;
        we_prev  = fb_we;
        cmd_prev = cmd_strobe;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic d, input int nbits);
        oled_cs = 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            oled_sck = 1'b0; oled_mosi = b[i]; oled_dc = d;
            tick(3);
            oled_sck = 1'b1;
            tick(3);
        end
    endtask

    task automatic cs_high();
        oled_cs = 1'b1;
        tick(3);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_bits(b, 1'b0, 8);
        cs_high();
    endtask

    task automatic data(input logic [7:0] b);
        send_bits(b, 1'b1, 8);
        cs_high();
    endtask

    logic [7:0] init_seq [23] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hD5, 8'h80,
                                  8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'hA1, 8'hC8, 8'hD9,
                                  8'hF1, 8'hDB, 8'h40, 8'h8D, 8'h14, 8'hA4, 8'hAF};
    int win_addr [7] = '{272, 273, 274, 400, 401, 402, 272};

    initial begin
        int base_we, base_cmd, idx0, errs;
        logic [7:0] kb;

        // T1: reset values, reset mid-byte, clean decode afterwards
        tick(3);
        chk("rst_contrast", 32'(contrast), 32'h7F);
        chk("rst_display_on", 32'(display_on), 0);
        rst_n = 1'b1;
        tick(2);
        send_bits(8'hAF, 1'b0, 4);
        rst_n = 1'b0;
        tick(2);
        chk("t1_fb_we", 32'(fb_we), 0);
        chk("t1_cmd_strobe", 32'(cmd_strobe), 0);
        chk("t1_fb_addr", 32'(fb_addr), 0);
        chk("t1_fb_wdata", 32'(fb_wdata), 0);
        chk("t1_cmd_byte", 32'(cmd_byte), 0);
        chk("t1_display_on", 32'(display_on), 0);
        chk("t1_contrast", 32'(contrast), 32'h7F);
        chk("t1_inverted", 32'(inverted), 0);
        rst_n = 1'b1;
        tick(2);
        cs_high();
        base_cmd = cmd_cnt;
        cmd(8'hAF);
        chk("t1_cmd_cnt", 32'(cmd_cnt - base_cmd), 1);
        chk("t1_cmd_byte_af", 32'(cmd_byte), 32'hAF);
        chk("t1_display_on_af", 32'(display_on), 1);

        // T2: init stream
        base_cmd = cmd_cnt;
        base_we  = we_cnt;
        foreach (init_seq[i]) cmd(init_seq[i]);
        chk("t2_cmd_cnt", 32'(cmd_cnt - base_cmd), 23);
        chk("t2_no_we", 32'(we_cnt - base_we), 0);
        chk("t2_display_on", 32'(display_on), 1);
        chk("t2_contrast", 32'(contrast), 32'h7F);
        chk("t2_inverted", 32'(inverted), 0);
        chk("t2_cmd_byte", 32'(cmd_byte), 32'hAF);

        // T3: full frame, cs held low for the whole burst, then wrap
        base_we = we_cnt;
        idx0    = addr_q.size();
        for (int k = 0; k < 1024; k++) begin
            kb = k[7:0];
            send_bits(kb, 1'b1, 8);
        end
        cs_high();
        chk("t3_we_cnt", 32'(we_cnt - base_we), 1024);
        errs = 0;
        for (int k = 0; k < 1024; k++) begin
            kb = k[7:0];
            if (idx0 + k >= addr_q.size()) errs++;
            else if (addr_q[idx0 + k] !== 10'(k) || data_q[idx0 + k] !== kb) errs++;
        end
        chk("t3_addr_data_errs", 32'(errs), 0);
        data(8'hEE);
        chk("t3_wrap_cnt", 32'(we_cnt - base_we), 1025);
        chk("t3_wrap_addr", 32'(fb_addr), 0);
        chk("t3_wrap_data", 32'(fb_wdata), 32'hEE);

        // T4: column 16..18, page 2..3 window
        cmd(8'h21); cmd(8'h10); cmd(8'h12);
        cmd(8'h22); cmd(8'h02); cmd(8'h03);
        idx0 = addr_q.size();
        for (int i = 0; i < 7; i++) data(8'hA0 + 8'(i));
        chk("t4_we_cnt", 32'(addr_q.size() - idx0), 7);
        for (int i = 0; i < 7; i++)
            if (idx0 + i < addr_q.size())
                chk($sformatf("t4_addr%0d", i), 32'(addr_q[idx0 + i]), 32'(win_addr[i]));

        // T5: partial byte aborted by cs
        cmd(8'hAE);
        chk("t5_display_off", 32'(display_on), 0);
        base_cmd = cmd_cnt;
        send_bits(8'hFF, 1'b0, 5);
        cs_high();
        cmd(8'hAF);
        chk("t5_cmd_cnt", 32'(cmd_cnt - base_cmd), 1);
        chk("t5_cmd_byte", 32'(cmd_byte), 32'hAF);
        chk("t5_display_on", 32'(display_on), 1);

        // T6: data cancels pending argument; panel reset restores state
        oled_reset = 1'b0; tick(4);
        oled_reset = 1'b1; tick(4);
        base_we = we_cnt;
        cmd(8'h81);
        data(8'h55);
        chk("t6_contrast", 32'(contrast), 32'h7F);
        chk("t6_we_cnt", 32'(we_cnt - base_we), 1);
        chk("t6_addr", 32'(fb_addr), 0);
        chk("t6_wdata", 32'(fb_wdata), 32'h55);
        cmd(8'h10);
        chk("t6_idle_contrast", 32'(contrast), 32'h7F);
        cmd(8'h81); cmd(8'h33);
        chk("t6_contrast_load", 32'(contrast), 32'h33);
        cmd(8'hA7); cmd(8'hAF);
        chk("t6_inverted_set", 32'(inverted), 1);
        oled_reset = 1'b0; tick(4);
        chk("t6_rst_contrast", 32'(contrast), 32'h7F);
        chk("t6_rst_inverted", 32'(inverted), 0);
        chk("t6_rst_display_on", 32'(display_on), 0);
        chk("t6_rst_fb_addr", 32'(fb_addr), 0);
        chk("t6_rst_fb_wdata", 32'(fb_wdata), 0);
        chk("t6_rst_cmd_byte", 32'(cmd_byte), 0);
        oled_reset = 1'b1; tick(4);
        cmd(8'h21); cmd(8'h05); cmd(8'h07);
        data(8'h11); data(8'h66);
        chk("t6_post_rst_wdata", 32'(fb_wdata), 32'h66);
        chk("t6_post_rst_addr", 32'(fb_addr), 6);

        chk("strobe_width", 32'(wide_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
